vblank_scheduler: RTL
=====================

VBLANK_SCHEDULER -- requirements
Module: vblank_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of game-logic requesters sharing game-state access.
REQ-002 Parameter TIMEOUT, default 1024: maximum grant length in clk cycles.
REQ-003 Parameter VB_START, default 516: first vCount line of vertical blanking.
REQ-004 Parameter VB_END, default 35: first vCount line of active video.
REQ-005 Port clk, input, 1: system clock; the only clock.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port vCount, input, 10: current display line from the display controller.
REQ-008 Port req, input, NUM_REQ: per-requester level request for a game-state update slot.
REQ-009 Port done, input, NUM_REQ: per-requester one-cycle pulse meaning the slot is finished.
REQ-010 Port err_clr, input, 1: one-cycle pulse that clears timeout_err.
REQ-011 Port gnt, output, NUM_REQ: one-hot or zero; the granted requester may write game state.
REQ-012 Port frame_tick, output, 1: one-cycle pulse at the start of vertical blanking.
REQ-013 Port busy, output, 1: high while in the SCAN or GRANT state.
REQ-014 Port overrun, output, 1: one-cycle pulse when a grant is cut off by active video.
REQ-015 Port timeout_err, output, NUM_REQ: sticky per-requester timeout flags.

Function
REQ-016 The block SHALL compute vb = (vCount >= VB_START) || (vCount < VB_END) and register it once into vb_q.
REQ-017 The block SHALL pulse frame_tick for exactly one cycle in the cycle after the cycle in which vb_q rises.
REQ-018 The FSM SHALL have the states ACTIVE, SCAN, GRANT and DONE, and SHALL reset to ACTIVE.
REQ-019 In ACTIVE, when vb_q rises, the FSM SHALL snapshot req into pending, set ptr=0 and go to SCAN.
REQ-020 In SCAN, the FSM SHALL select the lowest index i >= ptr with pending[i]=1, load cnt=0 and go to GRANT in one cycle.
REQ-021 In SCAN, if no such index exists, the FSM SHALL go to DONE.
REQ-022 In GRANT, gnt[i] SHALL be 1 and every other gnt bit SHALL be 0; gnt SHALL be 0 in all other states.
REQ-023 In GRANT, done[i]=1 SHALL clear pending[i], set ptr=i+1 and return the FSM to SCAN, so each grant is followed by one idle SCAN cycle.
REQ-024 done on any non-granted line, or done in a non-GRANT state, SHALL be ignored.
REQ-025 In GRANT, cnt SHALL increment each cycle.
REQ-026 If cnt reaches TIMEOUT-1 without done[i], the block SHALL set timeout_err[i], clear pending[i], set ptr=i+1 and go to SCAN.
REQ-027 If done[i] and the timeout condition occur in the same cycle, done SHALL win and timeout_err SHALL NOT be set.
REQ-028 If vb_q falls while in GRANT, the block SHALL deassert gnt in the next cycle, pulse overrun once and go to ACTIVE; the preempted requester is served in the next frame only if it still requests.
REQ-029 If vb_q falls while in SCAN, the FSM SHALL go to ACTIVE without pulsing overrun.
REQ-030 In DONE, the FSM SHALL remain until vb_q falls, then go to ACTIVE.
REQ-031 Requests rising after the snapshot SHALL NOT be granted before the next frame.
REQ-032 Each requester SHALL be granted at most once per frame, in ascending index order.
REQ-033 err_clr SHALL zero timeout_err; a timeout in the same cycle SHALL take priority, leaving that bit set.
REQ-034 ptr SHALL be clog2(NUM_REQ)+1 bits wide so that ptr = NUM_REQ is representable, and it SHALL NOT wrap within a frame.
REQ-035 cnt SHALL be clog2(TIMEOUT) bits wide.
REQ-036 busy SHALL equal 1 exactly when the state is SCAN or GRANT.

Reset
REQ-037 While reset=1, the block SHALL asynchronously force gnt=0, frame_tick=0, overrun=0, busy=0, timeout_err=0, pending=0, ptr=0, cnt=0, vb_q=0 and state=ACTIVE.
REQ-038 Assertion of reset in the middle of a grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-039 After reset is released, the first frame_tick SHALL occur on the first rising edge of vb_q.
REQ-040 If vCount is already in blanking when reset is released, the first frame_tick SHALL occur one cycle after release.

Verification
REQ-041 Stimulus: req=4'b1011, each grant answered with done 3 cycles after grant -> frame_tick, then grants 0, 1, 3 in order, one idle cycle between grants, then DONE and busy=0.
REQ-042 Stimulus: requester 2 granted and never asserts done, TIMEOUT=16 -> gnt[2] held 16 cycles, timeout_err=4'b0100, scheduler proceeds to requester 3; err_clr then returns timeout_err to 0.
REQ-043 Stimulus: vCount enters active video (reaches 35) while gnt[0]=1 -> gnt=0 next cycle, overrun pulses once, requester 0 granted first in the next frame.
REQ-044 Stimulus: req[1] rises 5 cycles after frame_tick -> no grant to requester 1 this frame; gnt[1] in the next frame.
REQ-045 Stimulus: reset asserted mid-grant -> gnt=0 and busy=0 asynchronously; after release and the next blanking edge, normal scheduling resumes from index 0.
REQ-046 Stimulus: done on a non-granted line, and done coinciding with cnt=TIMEOUT-1 -> the first is ignored; the second clears pending with no timeout_err bit set.

Source files
------------

// File: rtl/vblank_scheduler.sv
// Hands out game-state write slots to requesters during vertical blanking, one at a time,
// in ascending index order, with a per-grant timeout and preemption when active video begins.
module vblank_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned VB_START = 516,
  parameter int unsigned VB_END   = 35
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         vCount,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic               err_clr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               frame_tick,
  output logic               busy,
  output logic               overrun,
  output logic [NUM_REQ-1:0] timeout_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = $clog2(NUM_REQ) + 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [9:0]      VbStart = 10'(VB_START);
  localparam logic [9:0]      VbEnd   = 10'(VB_END);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StActive, StScan, StGrant, StDone} state_e;

  state_e              state_q, state_d;
  logic                vb, vb_q, vb_prev_q, vb_rise;
  logic                frame_tick_q, overrun_q, overrun_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [NUM_REQ-1:0]  timeout_err_q, timeout_err_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                scan_found;
  logic [IdxW-1:0]     scan_idx;

  assign vb      = (vCount >= VbStart) || (vCount < VbEnd);
  assign vb_rise = vb_q & ~vb_prev_q;

  // Lowest pending index at or above ptr; ptr never wraps, so each requester is served once.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i] && (PtrW'(i) >= ptr_q)) begin
        scan_found = 1'b1;
        scan_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    overrun_d     = 1'b0;
    timeout_err_d = err_clr ? '0 : timeout_err_q;
    unique case (state_q)
      StActive: begin
        if (vb_rise) begin
          pending_d = req;
          ptr_d     = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (!vb_q) begin
          state_d = StActive;
        end else if (scan_found) begin
          idx_d   = scan_idx;
          cnt_d   = '0;
          state_d = StGrant;
        end else begin
          state_d = StDone;
        end
      end
      StGrant: begin
        if (!vb_q) begin
          overrun_d = 1'b1;
          state_d   = StActive;
        end else if (done[idx_q] || (cnt_q == CntMax)) begin
          // done outranks a coinciding timeout
          if (!done[idx_q]) timeout_err_d[idx_q] = 1'b1;
          pending_d[idx_q] = 1'b0;
          ptr_d            = PtrW'(idx_q) + PtrW'(1);
          state_d          = StScan;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (!vb_q) state_d = StActive;
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StActive;
      vb_q          <= 1'b0;
      vb_prev_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
      overrun_q     <= 1'b0;
      pending_q     <= '0;
      timeout_err_q <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      vb_q          <= vb;
      vb_prev_q     <= vb_q;
      frame_tick_q  <= vb_rise;
      overrun_q     <= overrun_d;
      pending_q     <= pending_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
    end
  end

  // Decoded from state so that reset removes the grant without a clock edge.
  always_comb begin
    gnt = '0;
    if (state_q == StGrant) gnt[idx_q] = 1'b1;
  end

  assign busy        = (state_q == StScan) || (state_q == StGrant);
  assign frame_tick  = frame_tick_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
